// File: rtl/data_mem_responder.sv
// Single-port word memory answering one load/store request at a time, with byte-lane stores.
// Latency: response strobe LATENCY+1 cycles after the accepting handshake; one request per LATENCY+2 cycles.
// Backpressure: req_ready is low from acceptance through the response cycle; the response cannot be stalled.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Word index width; a one-word memory still needs a one-bit index.
    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    // Wait-counter preload; unused when LATENCY is zero.
    localparam logic [2:0] LAT_M1    = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);
    // Upper bound on the word address, sized to compare against addr[31:2].
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t        state;
    state_t        state_nxt;
    logic [2:0]    cnt;
    logic [2:0]    cnt_nxt;
    req_t          req_live;
    req_t          req_q;
    req_t          req_cur;
    logic          accept;
    logic          enter_resp;
    logic          cur_err;
    logic [AW-1:0] cur_idx;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    // Ready is a pure function of state so it never loops back through req_valid.
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    assign req_live  = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};

    // With LATENCY=0 the memory is touched on the accepting edge itself, before the
    // latched copy exists, so the live request is used while still in IDLE.
    assign req_cur   = (state == IDLE) ? req_live : req_q;

    assign cur_err   = (req_cur.addr[1:0] != 2'b00) || (req_cur.addr[31:2] >= DEPTH_LIM);
    assign cur_idx   = req_cur.addr[AW+1:2];

    // The memory operation happens on the edge that enters RESP; reset suppresses it.
    assign enter_resp = rst && (state_nxt == RESP);

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // State and counter registers; reset aborts any request in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Capture the request at the handshake edge; held stable until the response.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= req_live;
        end
    end

    // Byte-lane store into the memory; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (enter_resp && req_cur.we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_cur.be[i]) begin
                    mem[cur_idx][8*i +: 8] <= req_cur.wdata[8*i +: 8];
                end
            end
        end
    end

    // Response payload: loaded word or zero, plus error flag, present only during RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            err_q   <= cur_err;
            rdata_q <= (!cur_err && !req_cur.we) ? mem[cur_idx] : 32'd0;
        end else begin
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk;
    logic        rst;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        req_valid0;
    logic        req_ready0;
    logic        req_we0;
    logic [31:0] req_addr0;
    logic [31:0] req_wdata0;
    logic [3:0]  req_be0;
    logic        rsp_valid0;
    logic [31:0] rsp_rdata0;
    logic        rsp_err0;

    int total;
    int bad;

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(64), .LATENCY(0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_we    (req_we0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .req_be    (req_be0),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0),
        .rsp_err   (rsp_err0)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Drive one request on the LATENCY=2 instance and report what came back.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic got, output logic [31:0] rd,
                        output logic er, output int lat, output logic rdy_hi, output logic leak);
        int n;
        got = 1'b0; rd = 32'd0; er = 1'b0; lat = 0; rdy_hi = 1'b0; leak = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (req_ready) rdy_hi = 1'b1;
            if (rsp_valid) begin
                got = 1'b1; rd = rsp_rdata; er = rsp_err; lat = k;
                break;
            end
            if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) leak = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL reset_req_ready0 got=%b want=1", req_ready0); end
        total++; if (rsp_valid0 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid0 got=%b want=0", rsp_valid0); end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load;
        logic got, er, rdy_hi, leak;
        logic [31:0] rd;
        int lat;
        xact(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL st_got got=%b want=1", got); end
        total++; if (lat != 3) begin bad++; $display("FAIL st_latency got=%0d want=3", lat); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL st_err got=%b want=0", er); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL st_rdata got=%h want=0", rd); end
        total++; if (rdy_hi !== 1'b0) begin bad++; $display("FAIL st_ready_busy got=%b want=0", rdy_hi); end
        total++; if (leak !== 1'b0) begin bad++; $display("FAIL st_idle_outputs got=%b want=0", leak); end
        xact(1'b0, 32'h8, 32'h0, 4'h0, got, rd, er, lat, rdy_hi, leak);
        total++; if (lat != 3) begin bad++; $display("FAIL ld_latency got=%0d want=3", lat); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_rdata got=%h want=deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_err got=%b want=0", er); end
    endtask

    task automatic test_partial_store;
        logic got, er, rdy_hi, leak;
        logic [31:0] rd;
        int lat;
        xact(1'b1, 32'h8, 32'h11223344, 4'b0101, got, rd, er, lat, rdy_hi, leak);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL part_st_err got=%b want=0", er); end
        xact(1'b0, 32'h8, 32'h0, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL part_ld_rdata got=%h want=de22be44", rd); end
        xact(1'b1, 32'h8, 32'hFFFFFFFF, 4'b0000, got, rd, er, lat, rdy_hi, leak);
        total++; if (got !== 1'b1) begin bad++; $display("FAIL be0_got got=%b want=1", got); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL be0_err got=%b want=0", er); end
        xact(1'b0, 32'h8, 32'h0, 4'h0, got, rd, er, lat, rdy_hi, leak);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL be0_ld_rdata got=%h want=de22be44", rd); end
    endtask

    task automatic test_errors;
        logic got, er, rdy_hi, leak;
        logic [31:0] rd;
        int lat;
        xact(1'b1, 32'h0, 32'h01234567, 4'hF, got, rd, er, lat, rdy_hi, leak);
        xact(1'b1, 32'hFC, 32'h89ABCDEF, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL top_word_st_err got=%b want=0", er); end
        xact(1'b0, 32'h6, 32'h0, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_ld_err got=%b want=1", er); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL misalign_ld_rdata got=%h want=0", rd); end
        total++; if (lat != 3) begin bad++; $display("FAIL misalign_ld_latency got=%0d want=3", lat); end
        xact(1'b1, 32'h100, 32'hAAAAAAAA, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL range_st_err got=%b want=1", er); end
        total++; if (rd !== 32'd0) begin bad++; $display("FAIL range_st_rdata got=%h want=0", rd); end
        xact(1'b1, 32'h2, 32'h55555555, 4'hF, got, rd, er, lat, rdy_hi, leak);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL misalign_st_err got=%b want=1", er); end
        xact(1'b0, 32'h0, 32'h0, 4'h0, got, rd, er, lat, rdy_hi, leak);
        total++; if (rd !== 32'h01234567) begin bad++; $display("FAIL word0_unchanged got=%h want=01234567", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL word0_err got=%b want=0", er); end
        xact(1'b0, 32'hFC, 32'h0, 4'h0, got, rd, er, lat, rdy_hi, leak);
        total++; if (rd !== 32'h89ABCDEF) begin bad++; $display("FAIL top_word_ld got=%h want=89abcdef", rd); end
    endtask

    task automatic test_reset_mid_op;
        logic got, er, rdy_hi, leak;
        logic [31:0] rd;
        int lat;
        logic seen;
        xact(1'b1, 32'h4, 32'h5A5A5A5A, 4'hF, got, rd, er, lat, rdy_hi, leak);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rmid_accept_ready got=%b want=1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        rst = 1'b0;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rmid_no_response got=%b want=0", seen); end
        xact(1'b0, 32'h4, 32'h0, 4'h0, got, rd, er, lat, rdy_hi, leak);
        total++; if (rd !== 32'h5A5A5A5A) begin bad++; $display("FAIL rmid_prior_contents got=%h want=5a5a5a5a", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL rmid_ld_err got=%b want=0", er); end
    endtask

    task automatic test_latency0;
        logic exp_rdy, exp_rv;
        int acc;
        req_valid0 = 1'b1; req_we0 = 1'b1; req_addr0 = 32'hC; req_wdata0 = 32'h0BADCAFE; req_be0 = 4'hF;
        @(negedge clk);
        total++; if (req_ready0 !== 1'b1) begin bad++; $display("FAIL l0_st_ready got=%b want=1", req_ready0); end
        @(posedge clk); #1;
        req_valid0 = 1'b0; req_we0 = 1'b0;
        @(negedge clk);
        total++; if (rsp_valid0 !== 1'b1) begin bad++; $display("FAIL l0_st_rsp_valid got=%b want=1", rsp_valid0); end
        total++; if (rsp_err0 !== 1'b0) begin bad++; $display("FAIL l0_st_err got=%b want=0", rsp_err0); end
        @(posedge clk); #1;
        acc = 0;
        req_valid0 = 1'b1; req_we0 = 1'b0; req_addr0 = 32'hC;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_rdy = ((c % 2) == 0);
            exp_rv  = ((c % 2) == 1);
            total++; if (req_ready0 !== exp_rdy) begin bad++; $display("FAIL l0_ready c=%0d got=%b want=%b", c, req_ready0, exp_rdy); end
            total++; if (rsp_valid0 !== exp_rv) begin bad++; $display("FAIL l0_rsp_valid c=%0d got=%b want=%b", c, rsp_valid0, exp_rv); end
            if (exp_rv) begin
                total++; if (rsp_rdata0 !== 32'h0BADCAFE) begin bad++; $display("FAIL l0_rdata c=%0d got=%h want=0badcafe", c, rsp_rdata0); end
            end
            if (req_ready0 && req_valid0) acc++;
            @(posedge clk); #1;
        end
        req_valid0 = 1'b0;
        total++; if (acc != 3) begin bad++; $display("FAIL l0_accepts got=%0d want=3", acc); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        logic [31:0] expd  [3];
        logic exp_rdy, exp_rv, hit;
        int acc, nrsp;
        addrs[0] = 32'h8;  expd[0] = 32'hDE22BE44;
        addrs[1] = 32'h0;  expd[1] = 32'h01234567;
        addrs[2] = 32'hFC; expd[2] = 32'h89ABCDEF;
        acc = 0; nrsp = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0]; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            exp_rdy = (c >= 12) || ((c % 4) == 0);
            exp_rv  = (c < 12) && ((c % 4) == 3);
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
            total++; if (rsp_valid !== exp_rv) begin bad++; $display("FAIL b2b_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, exp_rv); end
            if (rsp_valid && nrsp < 3) begin
                total++; if (rsp_rdata !== expd[nrsp]) begin bad++; $display("FAIL b2b_rdata n=%0d got=%h want=%h", nrsp, rsp_rdata, expd[nrsp]); end
            end
            if (rsp_valid) nrsp++;
            hit = req_ready && req_valid;
            @(posedge clk); #1;
            if (hit) begin
                acc++;
                if (acc < 3) req_addr = addrs[acc];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        total++; if (nrsp != 3) begin bad++; $display("FAIL b2b_pulses got=%0d want=3", nrsp); end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        total = 0;
        bad = 0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'd0; req_wdata0 = 32'd0; req_be0 = 4'd0;
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_reset_mid_op();
        test_latency0();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, SHALL set the number of 32-bit storage words; valid word index range is 0..DEPTH_WORDS-1.
REQ-002 Parameter LATENCY, default 2, range 0..7, SHALL set the number of wait cycles between request acceptance and response.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk; no asynchronous path.
REQ-005 req_valid  input  1  initiator has a request pending.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_be  input  4  store byte enables; bit i selects byte lane i (bits 8i+7:8i).
REQ-011 rsp_valid  output  1  one-cycle response strobe.
REQ-012 rsp_rdata  output  32  load data; valid only when rsp_valid=1.
REQ-013 rsp_err  output  1  request rejected; valid only when rsp_valid=1.

Function
REQ-014 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 in IDLE and 0 in WAIT and RESP, and SHALL depend on state only, never combinationally on req_valid.
REQ-016 Handshake: a request is accepted on a rising edge where req_valid=1 and req_ready=1; req_we, req_addr, req_wdata and req_be SHALL be latched at that edge.
REQ-017 On acceptance, the FSM SHALL go IDLE->WAIT with the wait counter loaded to LATENCY-1 when LATENCY>=1, or go IDLE->RESP directly when LATENCY=0.
REQ-018 In WAIT, the counter SHALL decrement each cycle; when it is 0, the next edge SHALL go WAIT->RESP.
REQ-019 rsp_valid SHALL be 1 only in RESP, for exactly one cycle per accepted request, LATENCY+1 cycles after the handshake cycle.
REQ-020 RESP->IDLE SHALL occur unconditionally on the next edge; the initiator cannot stall the response.
REQ-021 Throughput SHALL be at most one request per LATENCY+2 cycles.
REQ-022 A request is in error when latched addr[1:0] != 0 or when addr[31:2] >= DEPTH_WORDS.
REQ-023 Store, no error: on the edge entering RESP, only byte lanes with be=1 SHALL be written at word addr[31:2]; other lanes SHALL be unchanged.
REQ-024 Store with be=4'b0000 SHALL complete normally, with no memory change and rsp_err=0.
REQ-025 Load, no error: rsp_rdata SHALL be the full word at addr[31:2], registered on the edge entering RESP; req_be SHALL be ignored.
REQ-026 Store followed by a load to the same word SHALL return the updated data.
REQ-027 Error request: the memory SHALL not be written, and the response SHALL be rsp_err=1 with rsp_rdata=0.
REQ-028 Successful request: the response SHALL be rsp_err=0; a store response SHALL have rsp_rdata=0.
REQ-029 req_valid in WAIT or RESP SHALL be ignored; the initiator holds the request until req_ready=1.
REQ-030 Outside RESP, rsp_rdata and rsp_err SHALL be driven to 0.

Reset
REQ-031 While rst=0 at an edge, the responder SHALL take state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL be 1 from the first cycle after reset release.
REQ-032 Reset asserted in WAIT SHALL abort the request: no memory write, and no response ever issued for it.
REQ-033 Storage contents SHALL not be affected by reset.

Verification
REQ-034 LATENCY=2: store addr=0x8, wdata=0xDEADBEEF, be=4'hF at cycle 0; then load addr=0x8 -> store rsp_valid at cycle 3, err=0; load rsp_rdata=0xDEADBEEF, err=0.
REQ-035 Partial store: word 0x8 = 0xDEADBEEF; store wdata=0x11223344, be=4'b0101 -> load returns 0xDE22BE44.
REQ-036 Errors: load addr=0x6 -> rsp_err=1, rdata=0; store addr=0x100 (DEPTH_WORDS=64) -> rsp_err=1; the next load of word 0 is unchanged.
REQ-037 LATENCY=0: load accepted at cycle 0 -> rsp_valid at cycle 1; req_ready=0 at cycle 1 and 1 at cycle 2; req_valid held high throughout -> exactly one accept per 2 cycles.
REQ-038 Reset mid-op: store 0xCAFEF00D to 0x4, then rst=0 one cycle after acceptance -> no rsp_valid; after reset, load 0x4 returns the prior contents.
REQ-039 Back-to-back: req_valid held high with 3 queued loads -> exactly 3 rsp_valid pulses, LATENCY+2 cycles apart, and req_ready never 1 in WAIT or RESP.
